servo_pwm_3ch: RTL and testbench

Three-channel hobby-servo PWM generator for the arm's X/Y/Z joints. It consumes the three 8-bit position commands from the mode-select state machine (accelerometer / ROM / idle-zero) and produces one servo pulse per channel per frame. New commands are latched only at frame boundaries, and each channel is slew-rate limited so that a mode switch does not slam the joints.

---
 rtl/servo_pwm_3ch.sv | 120 ++++++++++++
 tb/tb_servo_pwm_3ch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_3ch.sv
// Three-channel servo PWM: one pulse per channel per frame, commands latched and
// slew-limited at frame boundaries; pwm outputs registered from next-state counters.
module servo_pwm_3ch #(
  parameter int CLKS_PER_US = 50,
  parameter int FRAME_US    = 20000,
  parameter int MIN_US      = 1000,
  parameter int US_PER_LSB  = 4,
  parameter int MAX_STEP    = 4,
  parameter int CENTER      = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [7:0] cmd_z,
  output logic       pwm_x,
  output logic       pwm_y,
  output logic       pwm_z,
  output logic [7:0] pos_x,
  output logic [7:0] pos_y,
  output logic [7:0] pos_z,
  output logic       frame_start,
  output logic       settled
);

  localparam int UW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int FW = $clog2(FRAME_US);
  localparam logic [UW-1:0] US_LAST = UW'(CLKS_PER_US - 1);
  localparam logic [FW-1:0] FR_LAST = FW'(FRAME_US - 1);
  localparam logic [7:0]    CTR     = 8'(CENTER);
  localparam logic [7:0]    STEP8   = 8'(MAX_STEP);

  if ((FRAME_US <= MIN_US + 255 * US_PER_LSB) || (CLKS_PER_US < 1)) begin : g_illegal
    $error("servo_pwm_3ch: illegal parameter combination");
  end

  logic [UW-1:0] us_cnt, us_nxt;
  logic [FW-1:0] fr_cnt, fr_nxt;
  logic          boundary;
  logic          run, run_nxt;
  logic [7:0]    cmd     [3];
  logic [7:0]    pos     [3];
  logic [7:0]    pos_nxt [3];
  logic [7:0]    tgt     [3];
  logic [7:0]    tgt_nxt [3];
  logic [2:0]    pwm, pwm_nxt;
  logic          settled_nxt;

  assign cmd[0] = cmd_x;
  assign cmd[1] = cmd_y;
  assign cmd[2] = cmd_z;

  // Step toward the target by at most MAX_STEP; the target is always in range so no wrap.
  function automatic logic [7:0] slew(input logic [7:0] target, input logic [7:0] cur);
    int d;
    d = int'(target) - int'(cur);
    if (MAX_STEP == 0 || (d <= MAX_STEP && d >= -MAX_STEP)) return target;
    else if (d > 0) return cur + STEP8;
    else return cur - STEP8;
  endfunction

  function automatic logic [31:0] width_us(input logic [7:0] p);
    return 32'(MIN_US) + 32'(p) * 32'(US_PER_LSB);
  endfunction

  always_comb begin
    boundary = (us_cnt == US_LAST) && (fr_cnt == FR_LAST);
    us_nxt   = (us_cnt == US_LAST) ? '0 : us_cnt + UW'(1);
    fr_nxt   = fr_cnt;
    if (us_cnt == US_LAST) fr_nxt = (fr_cnt == FR_LAST) ? '0 : fr_cnt + FW'(1);
    run_nxt  = boundary ? enable : run;
    pwm_nxt  = '0;
    for (int i = 0; i < 3; i++) begin
      tgt_nxt[i] = tgt[i];
      pos_nxt[i] = pos[i];
      if (boundary && enable) begin
        tgt_nxt[i] = cmd[i];
        pos_nxt[i] = slew(cmd[i], pos[i]);
      end
      pwm_nxt[i] = run_nxt && (32'(fr_nxt) < width_us(pos_nxt[i]));
    end
    settled_nxt = (pos_nxt[0] == tgt_nxt[0]) && (pos_nxt[1] == tgt_nxt[1]) &&
                  (pos_nxt[2] == tgt_nxt[2]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      us_cnt      <= '0;
      fr_cnt      <= '0;
      run         <= 1'b0;
      pwm         <= '0;
      frame_start <= 1'b0;
      settled     <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        pos[i] <= CTR;
        tgt[i] <= CTR;
      end
    end else begin
      us_cnt      <= us_nxt;
      fr_cnt      <= fr_nxt;
      run         <= run_nxt;
      pwm         <= pwm_nxt;
      frame_start <= boundary;
      settled     <= settled_nxt;
      for (int i = 0; i < 3; i++) begin
        pos[i] <= pos_nxt[i];
        tgt[i] <= tgt_nxt[i];
      end
    end
  end

  assign pwm_x = pwm[0];
  assign pwm_y = pwm[1];
  assign pwm_z = pwm[2];
  assign pos_x = pos[0];
  assign pos_y = pos[1];
  assign pos_z = pos[2];

endmodule

// File: tb/tb_servo_pwm_3ch.sv
// Bench for servo_pwm_3ch: a slew-limited instance (a) and an unlimited one (b) share stimulus,
// each checked every cycle against a frame-arithmetic model plus directed literal expectations.
module tb_servo_pwm_3ch;
  localparam int CPU  = 2;
  localparam int FUS  = 1200;
  localparam int MINU = 100;
  localparam int UPL  = 4;
  localparam int FRC  = CPU * FUS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic [7:0] cmd_x = 8'd128, cmd_y = 8'd128, cmd_z = 8'd128;

  logic a_pwm_x, a_pwm_y, a_pwm_z, a_fs, a_settled;
  logic b_pwm_x, b_pwm_y, b_pwm_z, b_fs, b_settled;
  logic [7:0] a_pos_x, a_pos_y, a_pos_z, b_pos_x, b_pos_y, b_pos_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  servo_pwm_3ch #(.CLKS_PER_US(CPU), .FRAME_US(FUS), .MIN_US(MINU), .US_PER_LSB(UPL),
                  .MAX_STEP(4), .CENTER(128)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
    .pwm_x(a_pwm_x), .pwm_y(a_pwm_y), .pwm_z(a_pwm_z),
    .pos_x(a_pos_x), .pos_y(a_pos_y), .pos_z(a_pos_z),
    .frame_start(a_fs), .settled(a_settled));

  servo_pwm_3ch #(.CLKS_PER_US(CPU), .FRAME_US(FUS), .MIN_US(MINU), .US_PER_LSB(UPL),
                  .MAX_STEP(0), .CENTER(128)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
    .pwm_x(b_pwm_x), .pwm_y(b_pwm_y), .pwm_z(b_pwm_z),
    .pos_x(b_pos_x), .pos_y(b_pos_y), .pos_z(b_pos_z),
    .frame_start(b_fs), .settled(b_settled));

  logic [2:0] pwm_v [2];
  logic [7:0] pos_v [2][3];
  logic       fs_v  [2];
  logic       set_v [2];
  assign pwm_v[0] = {a_pwm_z, a_pwm_y, a_pwm_x};
  assign pwm_v[1] = {b_pwm_z, b_pwm_y, b_pwm_x};
  assign pos_v[0][0] = a_pos_x;
  assign pos_v[0][1] = a_pos_y;
  assign pos_v[0][2] = a_pos_z;
  assign pos_v[1][0] = b_pos_x;
  assign pos_v[1][1] = b_pos_y;
  assign pos_v[1][2] = b_pos_z;
  assign fs_v[0] = a_fs;
  assign fs_v[1] = b_fs;
  assign set_v[0] = a_settled;
  assign set_v[1] = b_settled;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: n = active edges since reset release; every FRC-th edge is a frame boundary.
  int n = 0;
  bit mrun = 1'b0;
  int mpos [2][3];
  int mtgt [2][3];
  int step [2] = '{4, 0};

  initial begin : model
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 3; c++) begin
        mpos[i][c] = 128;
        mtgt[i][c] = 128;
      end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        n = 0;
        mrun = 1'b0;
        for (int i = 0; i < 2; i++)
          for (int c = 0; c < 3; c++) begin
            mpos[i][c] = 128;
            mtgt[i][c] = 128;
          end
      end else begin
        n++;
        if (n % FRC == 0) begin
          mrun = enable;
          if (enable) begin
            for (int i = 0; i < 2; i++)
              for (int c = 0; c < 3; c++) begin
                int t, d;
                t = (c == 0) ? int'(cmd_x) : (c == 1) ? int'(cmd_y) : int'(cmd_z);
                d = t - mpos[i][c];
                mtgt[i][c] = t;
                if (step[i] == 0 || (d <= step[i] && d >= -step[i])) mpos[i][c] = t;
                else mpos[i][c] = mpos[i][c] + ((d > 0) ? step[i] : -step[i]);
              end
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic [28:0] got, exp;
        int p;
        p = n % FRC;
        exp = '0;
        for (int c = 0; c < 3; c++) begin
          exp[26 + c] = mrun && (p < CPU * (MINU + UPL * mpos[i][c]));
          exp[c*8 +: 8] = 8'(mpos[i][c]);
        end
        exp[25] = (n > 0) && (p == 0);
        exp[24] = (mpos[i][0] == mtgt[i][0]) && (mpos[i][1] == mtgt[i][1]) &&
                  (mpos[i][2] == mtgt[i][2]);
        got = {pwm_v[i], fs_v[i], set_v[i], pos_v[i][2], pos_v[i][1], pos_v[i][0]};
        chk((i == 0) ? "model_a" : "model_b", 32'(got), 32'(exp));
      end
    end
  end

  // Pulse width and dead-frame monitors, independent of the model's pwm rule.
  int wid [2][3];
  int cnt [2][3];
  int first_fs = -1;
  int dead_hits = 0;
  initial begin : monitor
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 3; c++) begin
        wid[i][c] = 0;
        cnt[i][c] = 0;
      end
    forever begin
      @(negedge clk);
      if (!rst) begin
        first_fs = -1;
        dead_hits = 0;
        for (int i = 0; i < 2; i++)
          for (int c = 0; c < 3; c++) cnt[i][c] = 0;
      end else begin
        if (first_fs < 0 && a_fs) first_fs = n;
        if (n < FRC && (pwm_v[0] != 3'b0 || pwm_v[1] != 3'b0)) dead_hits++;
        for (int i = 0; i < 2; i++)
          for (int c = 0; c < 3; c++)
            if (pwm_v[i][c]) cnt[i][c]++;
            else if (cnt[i][c] > 0) begin
              wid[i][c] = cnt[i][c];
              cnt[i][c] = 0;
            end
      end
    end
  end

  // Next negedge at which the frame phase equals ph, then step 1 time unit off the edge.
  task automatic to_phase(input int ph);
    int k;
    k = 0;
    @(negedge clk);
    while (!((n % FRC) == ph && n > 0) && k < 3 * FRC) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3 * FRC) chk("to_phase_timeout", 32'(k), 32'(0));
    #1;
  endtask

  initial begin : stim
    int rev [4] = '{136, 132, 128, 126};
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pos_x", 32'(a_pos_x), 128);
    chk("rst_settled", 32'(a_settled), 1);
    chk("rst_pwm", 32'({a_pwm_z, a_pwm_y, a_pwm_x}), 0);
    chk("rst_frame_start", 32'(a_fs), 0);
    cmd_x = 8'd0;
    cmd_y = 8'd128;
    cmd_z = 8'd255;
    #1 rst = 1'b1;

    to_phase(0);
    chk("first_fs_cycle", 32'(first_fs), 2400);
    chk("dead_frame_pwm", 32'(dead_hits), 0);
    chk("a_pos_x_f1", 32'(a_pos_x), 124);
    chk("b_pos_z_f1", 32'(b_pos_z), 255);
    chk("pulse_starts_with_fs", 32'({b_fs, b_pwm_z, b_pwm_y, b_pwm_x}), 15);
    to_phase(2300);
    chk("b_width_x_0", 32'(wid[1][0]), 200);
    chk("b_width_y_128", 32'(wid[1][1]), 1224);
    chk("b_width_z_255", 32'(wid[1][2]), 2240);
    chk("a_width_x_124", 32'(wid[0][0]), 1192);

    to_phase(60);
    chk("pre_rst_pwm_x", 32'(a_pwm_x), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_pwm_x", 32'({b_pwm_x, a_pwm_x}), 0);
    chk("async_rst_pos_x", 32'(a_pos_x), 128);
    repeat (3) @(negedge clk);
    cmd_x = 8'd140;
    cmd_y = 8'd128;
    cmd_z = 8'd128;
    #2 rst = 1'b1;

    to_phase(0);
    chk("first_fs_cycle_2", 32'(first_fs), 2400);
    chk("dead_frame_pwm_2", 32'(dead_hits), 0);
    chk("slew_1", 32'(a_pos_x), 132);
    chk("slew_1_settled", 32'(a_settled), 0);
    to_phase(0);
    chk("slew_2", 32'(a_pos_x), 136);
    to_phase(0);
    chk("slew_3", 32'(a_pos_x), 140);
    chk("slew_3_settled", 32'(a_settled), 1);
    cmd_x = 8'd126;
    for (int k = 0; k < 4; k++) begin
      to_phase(0);
      chk($sformatf("rev_%0d", k), 32'(a_pos_x), 32'(rev[k]));
    end
    chk("rev_settled", 32'(a_settled), 1);

    to_phase(100);
    enable = 1'b0;
    to_phase(2000);
    chk("a_width_after_drop", 32'(wid[0][0]), 1208);
    chk("b_width_after_drop", 32'(wid[1][0]), 1208);
    to_phase(0);
    cmd_x = 8'd200;
    chk("disabled_pwm", 32'({a_pwm_z, a_pwm_y, a_pwm_x}), 0);
    to_phase(1500);
    chk("held_a_pos_x", 32'(a_pos_x), 126);
    chk("held_b_pos_x", 32'(b_pos_x), 126);
    enable = 1'b1;
    to_phase(0);
    chk("resume_a_pos_x", 32'(a_pos_x), 130);
    chk("resume_b_pos_x", 32'(b_pos_x), 200);
    chk("resume_pwm_x", 32'({b_pwm_x, a_pwm_x}), 3);

    to_phase(2399);
    cmd_z = 8'd140;
    to_phase(0);
    cmd_z = 8'd100;
    chk("edge_cmd_a_z", 32'(a_pos_z), 132);
    chk("edge_cmd_b_z", 32'(b_pos_z), 140);
    to_phase(0);
    chk("next_cmd_a_z", 32'(a_pos_z), 128);
    chk("next_cmd_b_z", 32'(b_pos_z), 100);
    to_phase(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
